// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants; PARITY_BIT exists only with UART_TX_PARITY_EN.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_CLK_PER_BIT = 100;
  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } uart_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit timer counting 0..CLK_PER_BIT-1 with a one-cycle tick on the last count.
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);
  localparam int W = $clog2(CLK_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_PER_BIT - 1);
  assign pre_tick = cnt == W'(CLK_PER_BIT - 2);
  always_ff @(posedge clk)
    if (rst || clear || tick) cnt <= '0;
    else cnt <= cnt + W'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with flow-control hold; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data,
  input  logic                   new_data,
  input  logic                   block,
  output logic                   busy,
  output logic                   tx
);
  uart_state_e state;
  logic [UART_DATA_W-1:0] data_q;
  logic [2:0] idx;
  logic tick, pre_tick, clear;
  // Stop bit leaves one cycle early: the first IDLE cycle carries its last tx=1 cycle, so a byte accepted there follows gaplessly.
  assign clear = (state == IDLE) || (state == STOP_BIT && pre_tick);
  uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) baud (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .tick(tick),
    .pre_tick(pre_tick)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      idx <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE:
          if (new_data && !busy) begin
            state <= START_BIT;
            data_q <= data;
            tx <= 1'b0;
            busy <= 1'b1;
            idx <= '0;
          end else begin
            tx <= 1'b1;
            busy <= block;
          end
        START_BIT:
          if (tick) begin
            state <= DATA_BITS;
            tx <= data_q[0];
            idx <= '0;
          end
        DATA_BITS:
          if (tick) begin
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY_BIT;
              tx <= ^data_q;
`else
              state <= STOP_BIT;
              tx <= 1'b1;
`endif
            end else begin
              idx <= idx + 3'd1;
              tx <= data_q[idx + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
        PARITY_BIT:
          if (tick) begin
            state <= STOP_BIT;
            tx <= 1'b1;
          end
`endif
        STOP_BIT:
          if (pre_tick) begin
            state <= IDLE;
            busy <= block;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized bench against a queue-of-line-bits reference model.
module tb_uart_tx_serializer;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1, new_data = 1'b0, block = 1'b0;
  logic [7:0] data = '0;
  logic busy, tx;
  int n_chk = 0, n_fail = 0;
  bit q[$];
  logic [7:0] offer_q[$];
  bit blk_prev, rst_last;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .new_data(new_data),
    .block(block),
    .busy(busy),
    .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    bit bits[$];
    bits = {1'b0};
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (CPB) q.push_back(bits[i]);
  endtask

  task automatic step(input bit r, input bit nd, input logic [7:0] d, input bit b);
    bit etx, ebusy, nd_e;
    logic [7:0] d_e;
    @(negedge clk);
    etx = q.size() != 0 ? q[0] : 1'b1;
    ebusy = rst_last ? 1'b0 : (q.size() > 1 ? 1'b1 : blk_prev);
    check("tx", 32'(tx), 32'(etx));
    check("busy", 32'(busy), 32'(ebusy));
    nd_e = nd;
    d_e = d;
    if (!nd && !r && offer_q.size() != 0 && !ebusy) begin
      nd_e = 1'b1;
      d_e = offer_q.pop_front();
    end
    rst = r;
    new_data = nd_e;
    data = d_e;
    block = b;
    if (q.size() != 0) void'(q.pop_front());
    if (r) begin
      q.delete();
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (nd_e && !ebusy) push_frame(d_e);
    end
    blk_prev = b;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    rst_last = 1'b1;
    blk_prev = 1'b0;
    step(1'b0, 1'b1, 8'h68, 1'b0);
    idle(45);
    offer_q = '{8'h65, 8'h6C};
    idle(90);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(40);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (19) step(1'b0, 1'b1, 8'h41, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0);
    idle(45);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle(14);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    idle(45);
    repeat (600)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 9) == 0);
    idle(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
